des_sbox_engine: RTL and testbench



---
 rtl/des_sbox_engine.sv | 149 ++++++++++++++
 tb/tb_des_sbox_engine.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_sbox_engine.sv
// Iterative DES S-box substitution: evaluates LANES of the eight S-boxes per clock.
// Define DES_SBOX_OUT_PERM_EN to apply the DES P permutation to o_vector.
module des_sbox_engine #(
  parameter int LANES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [47:0] i_vector,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [31:0] o_vector,
  output logic        o_valid,
  input  logic        i_ready
);

  localparam int GROUPS = 8 / LANES;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
    $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
  end

  // Each table is 64 nibbles, row-major (row = {b5,b0}, column = b[4:1]), first entry in the MSBs.
  localparam logic [255:0] SBOX_TBL [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] b);
    int idx;
    idx = int'({b[5], b[0], b[4:1]});
    return SBOX_TBL[box][255 - 4*idx -: 4];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [47:0]        in_q, in_d;
  logic [31:0]        res_q, res_d;
  logic [31:0]        out_q, out_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;

  logic [2:0]         box_sel  [LANES];
  logic [3:0]         lane_nib [LANES];
  logic [31:0]        res_merged;
  logic [31:0]        result_out;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [5:0] chunk;
    assign box_sel[gi]  = 3'(int'(cnt_q) * LANES + gi);
    assign chunk        = in_q[47 - 6*int'(box_sel[gi]) -: 6];
    assign lane_nib[gi] = sbox_lookup(box_sel[gi], chunk);
  end

  // Current group's nibbles overlaid on the partial result, so the last group feeds o_vector directly.
  always_comb begin
    res_merged = res_q;
    for (int l = 0; l < LANES; l++) begin
      res_merged[(7 - int'(box_sel[l]))*4 +: 4] = lane_nib[l];
    end
  end

`ifdef DES_SBOX_OUT_PERM_EN
  localparam int P_TBL [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) begin
      y[31 - i] = x[32 - P_TBL[i]];
    end
    return y;
  endfunction

  assign result_out = p_perm(res_merged);
`else
  assign result_out = res_merged;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    res_d   = res_q;
    out_d   = out_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          in_d    = i_vector;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        res_d = res_merged;
        if (cnt_q == CNT_W'(GROUPS - 1)) begin
          out_d   = result_out;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      in_q    <= '0;
      res_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      res_q   <= res_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_vector = out_q;

endmodule

// File: tb/tb_des_sbox_engine.sv
// Directed bench for des_sbox_engine: scoreboard of expected words, reference S-box/P model.
module tb_des_sbox_engine;

  logic        clk;
  logic        rst;
  logic [47:0] i_vector;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] o_vector;
  logic        o_valid;
  logic        i_ready;

  logic [47:0] lat_vector;
  logic        lat_valid, lat_ready;
  logic        x1_ready, x4_ready, x8_ready;
  logic        x1_valid, x4_valid, x8_valid;
  logic [31:0] x1_vector, x4_vector, x8_vector;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  des_sbox_engine #(.LANES(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_vector(i_vector), .i_valid(i_valid), .o_ready(o_ready),
    .o_vector(o_vector), .o_valid(o_valid), .i_ready(i_ready));
  des_sbox_engine #(.LANES(1)) dut_l1 (
    .i_clk(clk), .i_rst(rst), .i_vector(lat_vector), .i_valid(lat_valid), .o_ready(x1_ready),
    .o_vector(x1_vector), .o_valid(x1_valid), .i_ready(lat_ready));
  des_sbox_engine #(.LANES(4)) dut_l4 (
    .i_clk(clk), .i_rst(rst), .i_vector(lat_vector), .i_valid(lat_valid), .o_ready(x4_ready),
    .o_vector(x4_vector), .o_valid(x4_valid), .i_ready(lat_ready));
  des_sbox_engine #(.LANES(8)) dut_l8 (
    .i_clk(clk), .i_rst(rst), .i_vector(lat_vector), .i_valid(lat_valid), .o_ready(x8_ready),
    .o_vector(x8_vector), .o_valid(x8_valid), .i_ready(lat_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // FIPS 46-3 S-boxes, four rows of sixteen per box.
  int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  int PT [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                  2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

  function automatic logic [31:0] model(input logic [47:0] v);
    logic [31:0] r;
    logic [31:0] p;
    logic [5:0]  c;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      c = v[47 - 6*k -: 6];
      r[31 - 4*k -: 4] = 4'(SB[k][int'(c[5])*32 + int'(c[0])*16 + int'(c[4:1])]);
    end
    p = r;
`ifdef DES_SBOX_OUT_PERM_EN
    for (int i = 0; i < 32; i++) p[31 - i] = r[32 - PT[i]];
`endif
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One word through the LANES=2 engine; expected value goes through the scoreboard.
  task automatic run_word(input logic [47:0] vec, input logic [31:0] exp, input string tag,
                          input bit chk_lat);
    int          lat;
    logic [31:0] e;
    i_vector = vec;
    i_valid  = 1'b1;
    chk({tag, "_ready"}, 48'(o_ready), 48'(1));
    exp_q.push_back(exp);
    tick();
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 30) begin
      tick();
      lat++;
    end
    if (chk_lat) chk({tag, "_lat"}, 48'(lat), 48'(4));
    else chk({tag, "_valid"}, 48'(o_valid), 48'(1));
    e = exp_q.pop_front();
    chk({tag, "_vec"}, 48'(o_vector), 48'(e));
    $display("txn %s in=%h out=%h exp=%h lat=%0d", tag, vec, o_vector, e, lat);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk({tag, "_drop"}, 48'(o_valid), 48'(0));
  endtask

  logic [31:0] zero_exp, r1_exp, s2_one_exp, s2_3e_exp;

  initial begin
    int          l1, l4, l8, acc, got, last_acc, lat;
    logic [31:0] e, held;
    logic [47:0] words [6];

    rst = 1'b1;
    i_vector = '0;  i_valid = 1'b0;  i_ready = 1'b0;
    lat_vector = '0; lat_valid = 1'b0; lat_ready = 1'b0;
`ifdef DES_SBOX_OUT_PERM_EN
    zero_exp   = model(48'h0);
    r1_exp     = 32'h234AA9BB;
    s2_one_exp = model(48'h001000000000);
    s2_3e_exp  = model(48'h03E000000000);
`else
    zero_exp   = 32'hEFA72C4D;
    r1_exp     = 32'h5C82B597;
    s2_one_exp = 32'hE3A72C4D;
    s2_3e_exp  = 32'hEFA72C4D;
`endif

    repeat (3) tick();
    chk("rst_ready", 48'(o_ready), 48'(0));
    chk("rst_valid", 48'(o_valid), 48'(0));
    chk("rst_vector", 48'(o_vector), 48'(0));
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 48'(o_ready), 48'(1));

    run_word(48'h000000000000, zero_exp, "zero", 1'b1);
    run_word(48'h6117BA866527, r1_exp, "round1", 1'b1);
    run_word(48'h001000000000, s2_one_exp, "s2_000001", 1'b1);
    run_word(48'h03E000000000, s2_3e_exp, "s2_111110", 1'b1);

    // Latency of the other lane counts, all fed the zero word together.
    chk("lat_x_ready", 48'({x1_ready, x4_ready, x8_ready}), 48'(3'b111));
    lat_vector = '0;
    lat_valid  = 1'b1;
    tick();
    lat_valid = 1'b0;
    l1 = -1; l4 = -1; l8 = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (x1_valid && l1 < 0) l1 = c;
      if (x4_valid && l4 < 0) l4 = c;
      if (x8_valid && l8 < 0) l8 = c;
    end
    chk("lat_lanes1", 48'(l1), 48'(8));
    chk("lat_lanes4", 48'(l4), 48'(2));
    chk("lat_lanes8", 48'(l8), 48'(1));
    chk("vec_lanes1", 48'(x1_vector), 48'(zero_exp));
    chk("vec_lanes4", 48'(x4_vector), 48'(zero_exp));
    chk("vec_lanes8", 48'(x8_vector), 48'(zero_exp));
    $display("txn lanes lat1=%0d lat4=%0d lat8=%0d", l1, l4, l8);
    lat_ready = 1'b1;
    tick();
    lat_ready = 1'b0;
    chk("lanes_drop", 48'({x1_valid, x4_valid, x8_valid}), 48'(3'b000));

    // Abort mid-BUSY: o_vector currently holds a nonzero result.
    i_vector = 48'h123456789ABC;
    i_valid  = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("abort_valid", 48'(o_valid), 48'(0));
    chk("abort_vector", 48'(o_vector), 48'(0));
    chk("abort_ready", 48'(o_ready), 48'(0));
    tick();
    rst = 1'b0;
    tick();
    chk("abort_post_ready", 48'(o_ready), 48'(1));
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (o_valid) got++;
      tick();
    end
    chk("abort_no_result", 48'(got), 48'(0));
    $display("txn abort in=123456789abc spurious_valid_cycles=%0d", got);

    // Backpressure with stray i_valid pulses during BUSY and DONE.
    i_vector = 48'hA5A5F0F01234;
    i_valid  = 1'b1;
    chk("bp_ready", 48'(o_ready), 48'(1));
    exp_q.push_back(model(48'hA5A5F0F01234));
    tick();
    i_vector = 48'hFFFFFFFFFFFF;
    lat = 0;
    while (!o_valid && lat < 30) begin
      chk("bp_busy_ready", 48'(o_ready), 48'(0));
      i_valid = ~i_valid;
      tick();
      lat++;
    end
    chk("bp_lat", 48'(lat), 48'(4));
    e = exp_q.pop_front();
    held = o_vector;
    chk("bp_vec", 48'(held), 48'(e));
    for (int c = 0; c < 5; c++) begin
      i_valid = (c % 2 == 0);
      chk("bp_hold_valid", 48'(o_valid), 48'(1));
      chk("bp_hold_vec", 48'(o_vector), 48'(e));
      chk("bp_done_ready", 48'(o_ready), 48'(0));
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("bp_drop", 48'(o_valid), 48'(0));
    chk("bp_keep_vec", 48'(o_vector), 48'(e));
    chk("bp_ready_back", 48'(o_ready), 48'(1));
    $display("txn backpressure in=a5a5f0f01234 out=%h exp=%h", held, e);
    repeat (6) tick();
    chk("bp_no_stray", 48'(o_valid), 48'(0));

    // Back-to-back with i_valid and i_ready held high.
    words = '{48'h6117BA866527, 48'h000000000000, 48'hFEDCBA987654,
              48'h0123456789AB, 48'h3C3C3C3C3C3C, 48'hC3C3C3C3C3C3};
    acc = 0; got = 0; last_acc = -1;
    i_ready  = 1'b1;
    i_valid  = 1'b1;
    i_vector = words[0];
    for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk("b2b_unexpected", 48'(o_vector), 48'hBAD);
        end else begin
          e = exp_q.pop_front();
          chk("b2b_vec", 48'(o_vector), 48'(e));
          $display("txn b2b word=%0d out=%h exp=%h", got, o_vector, e);
        end
        got++;
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(model(i_vector));
        if (last_acc >= 0) chk("b2b_interval", 48'(cyc - last_acc), 48'(6));
        last_acc = cyc;
        acc++;
      end
      tick();
      if (acc < 6) i_vector = words[acc];
      else i_valid = 1'b0;
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    chk("b2b_count", 48'(got), 48'(6));
    tick();

    // Every input value into every box, others held at zero.
    for (int k = 0; k < 8; k++) begin
      for (int v = 0; v < 64; v++) begin
        logic [47:0] vec;
        vec = 48'(v) << (6 * (7 - k));
        run_word(vec, model(vec), $sformatf("sweep_s%0d_%02h", k + 1, v), 1'b0);
      end
    end

    chk("scoreboard_empty", 48'(exp_q.size()), 48'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
